// File: rtl/spike_gen_scheduler.sv
// Spike generator scheduler: per-generator {period, ticks, tag} table swept on each
// time-unit pulse, emitting the tag of every generator that expires.
module spike_gen_scheduler #(
    parameter int Ngens   = 8,
    parameter int Nperiod = 16,
    parameter int Ntag    = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  time_unit,
    input  logic [Ngens-1:0]      gens_used,
    input  logic [2**Ngens-1:0]   gens_en,
    input  logic [Ngens-1:0]      prog_gen_idx,
    input  logic [Nperiod-1:0]    prog_period,
    input  logic [Nperiod-1:0]    prog_ticks,
    input  logic [Ntag-1:0]       prog_tag,
    input  logic                  prog_v,
    output logic                  prog_a,
    output logic [Ntag-1:0]       out_tag,
    output logic [Ngens-1:0]      out_gen_idx,
    output logic                  out_v,
    input  logic                  out_a,
    output logic                  busy,
    output logic                  missed_unit
);

    localparam int Depth = 2**Ngens;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_SWEEP, S_EMIT, S_DONE} state_t;

    state_t state, state_next;

    logic [Nperiod-1:0] period_mem [Depth];
    logic [Nperiod-1:0] ticks_mem  [Depth];
    logic [Ntag-1:0]    tag_mem    [Depth];

    logic [Ngens-1:0]   idx, idx_next, used, used_next;
    logic               pending, pending_next, missed_next;
    logic               out_v_next;
    logic [Ntag-1:0]    out_tag_next;
    logic [Ngens-1:0]   out_gen_idx_next;

    logic               we, we_all;
    logic [Ngens-1:0]   wr_addr;
    logic [Nperiod-1:0] wr_period, wr_ticks;
    logic [Ntag-1:0]    wr_tag;

    logic [Nperiod-1:0] rd_period, rd_ticks;
    logic [Ntag-1:0]    rd_tag;
    logic               active;

    assign rd_period = period_mem[idx];
    assign rd_ticks  = ticks_mem[idx];
    assign rd_tag    = tag_mem[idx];
    assign active    = gens_en[idx] && (rd_period != '0);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_next       = state;
        idx_next         = idx;
        used_next        = used;
        pending_next     = pending;
        missed_next      = missed_unit;
        out_v_next       = out_v;
        out_tag_next     = out_tag;
        out_gen_idx_next = out_gen_idx;
        prog_a           = 1'b0;
        we               = 1'b0;
        we_all           = 1'b0;
        wr_addr          = idx;
        wr_period        = '0;
        wr_ticks         = '0;
        wr_tag           = '0;

        case (state)
            S_INIT: begin
                we       = 1'b1;
                we_all   = 1'b1;
                idx_next = idx + Ngens'(1);
                if (&idx) state_next = S_IDLE;
            end
            S_IDLE: begin
                // A due sweep always beats programming in the same cycle
                if (time_unit || pending) begin
                    pending_next = 1'b0;
                    idx_next     = '0;
                    used_next    = gens_used;
                    state_next   = S_SWEEP;
                end else if (prog_v) begin
                    prog_a    = 1'b1;
                    we        = 1'b1;
                    we_all    = 1'b1;
                    wr_addr   = prog_gen_idx;
                    wr_period = prog_period;
                    wr_ticks  = prog_ticks;
                    wr_tag    = prog_tag;
                end
            end
            S_SWEEP: begin
                if (active && (rd_ticks <= Nperiod'(1))) begin
                    we               = 1'b1;
                    wr_ticks         = rd_period;
                    out_v_next       = 1'b1;
                    out_tag_next     = rd_tag;
                    out_gen_idx_next = idx;
                    state_next       = S_EMIT;
                end else begin
                    if (active) begin
                        we       = 1'b1;
                        wr_ticks = rd_ticks - Nperiod'(1);
                    end
                    if (idx == used) state_next = S_DONE;
                    else             idx_next   = idx + Ngens'(1);
                end
            end
            S_EMIT: begin
                if (out_a) begin
                    out_v_next = 1'b0;
                    if (idx == used) begin
                        state_next = S_DONE;
                    end else begin
                        idx_next   = idx + Ngens'(1);
                        state_next = S_SWEEP;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_INIT;
        endcase

        // One pulse may queue behind a running sweep; a second one is lost
        if (time_unit && (state == S_SWEEP || state == S_EMIT || state == S_DONE)) begin
            if (pending) missed_next  = 1'b1;
            else         pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_INIT;
            idx         <= '0;
            used        <= '0;
            pending     <= 1'b0;
            missed_unit <= 1'b0;
            out_v       <= 1'b0;
            out_tag     <= '0;
            out_gen_idx <= '0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            used        <= used_next;
            pending     <= pending_next;
            missed_unit <= missed_next;
            out_v       <= out_v_next;
            out_tag     <= out_tag_next;
            out_gen_idx <= out_gen_idx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && we) begin
            ticks_mem[wr_addr] <= wr_ticks;
            if (we_all) begin
                period_mem[wr_addr] <= wr_period;
                tag_mem[wr_addr]    <= wr_tag;
            end
        end
    end

endmodule

// File: tb/tb_spike_gen_scheduler.sv
// Directed bench for spike_gen_scheduler: table-driven pulse vectors plus
// hand-written stall, pending/missed and reset-during-emit sequences.
module tb_spike_gen_scheduler;

    logic          clk;
    logic          reset;
    logic          time_unit;
    logic [7:0]    gens_used;
    logic [255:0]  gens_en;
    logic [7:0]    prog_gen_idx;
    logic [15:0]   prog_period;
    logic [15:0]   prog_ticks;
    logic [10:0]   prog_tag;
    logic          prog_v;
    logic          prog_a;
    logic [10:0]   out_tag;
    logic [7:0]    out_gen_idx;
    logic          out_v;
    logic          out_a;
    logic          busy;
    logic          missed_unit;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  used;
        logic [3:0]  en;
        int          cnt;
        logic [10:0] tag;
        logic [7:0]  gidx;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    spike_gen_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .time_unit   (time_unit),
        .gens_used   (gens_used),
        .gens_en     (gens_en),
        .prog_gen_idx(prog_gen_idx),
        .prog_period (prog_period),
        .prog_ticks  (prog_ticks),
        .prog_tag    (prog_tag),
        .prog_v      (prog_v),
        .prog_a      (prog_a),
        .out_tag     (out_tag),
        .out_gen_idx (out_gen_idx),
        .out_v       (out_v),
        .out_a       (out_a),
        .busy        (busy),
        .missed_unit (missed_unit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_init();
        int cnt;
        logic acked;
        cnt   = 0;
        acked = 1'b0;
        while (busy && cnt < 400) begin
            #1;
            if (prog_a) acked = 1'b1;
            cnt++;
            @(negedge clk);
        end
        check_output("init_cycles", cnt, 256);
        check_output("init_no_ack", {31'b0, acked}, 0);
    endtask

    task automatic program_gen(input logic [7:0] g, input logic [15:0] p, input logic [15:0] t,
                               input logic [10:0] tg);
        logic ok;
        prog_gen_idx = g;
        prog_period  = p;
        prog_ticks   = t;
        prog_tag     = tg;
        prog_v       = 1'b1;
        ok           = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (prog_a) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        prog_v = 1'b0;
        check_output("prog_ack", {31'b0, ok}, 1);
    endtask

    task automatic pulse();
        time_unit = 1'b1;
        @(negedge clk);
        time_unit = 1'b0;
    endtask

    task automatic wait_out_v(input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_v) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_output(name, {31'b0, seen}, 1);
    endtask

    // One pulse, then watch a fixed window with out_a held high
    task automatic apply_stimulus(input int n);
        int          cnt;
        int          lat;
        logic [10:0] got_tag;
        logic [7:0]  got_idx;
        vec_t        v;
        v            = vecs[n];
        gens_used    = v.used;
        gens_en      = '0;
        gens_en[3:0] = v.en;
        out_a        = 1'b1;
        cnt          = 0;
        lat          = 0;
        got_tag      = '0;
        got_idx      = '0;
        pulse();
        for (int c = 1; c <= 10; c++) begin
            if (out_v) begin
                if (cnt == 0) lat = c;
                cnt++;
                got_tag = out_tag;
                got_idx = out_gen_idx;
            end
            @(negedge clk);
        end
        check_output($sformatf("vec%0d_emits", n), cnt, v.cnt);
        if (v.cnt > 0) begin
            check_output($sformatf("vec%0d_tag", n), {21'b0, got_tag}, {21'b0, v.tag});
            check_output($sformatf("vec%0d_gidx", n), {24'b0, got_idx}, {24'b0, v.gidx});
            check_output($sformatf("vec%0d_latency", n), lat, v.lat);
        end
        check_output($sformatf("vec%0d_idle", n), {31'b0, busy}, 0);
    endtask

    initial begin
        // gen 3 {4,2,0x155}: expires on pulses 2, 6, 10; idx 3 emits 5 cycles after sampling
        for (int i = 0; i < 12; i++) vecs[i] = '{8'd3, 4'b1000, 0, 11'h0, 8'd0, 0};
        vecs[1]  = '{8'd3, 4'b1000, 1, 11'h155, 8'd3, 5};
        vecs[5]  = '{8'd3, 4'b1000, 1, 11'h155, 8'd3, 5};
        vecs[9]  = '{8'd3, 4'b1000, 1, 11'h155, 8'd3, 5};
        // After reset the table is zeroed: nothing emits
        vecs[12] = '{8'd1, 4'b0011, 0, 11'h0, 8'd0, 0};
        // gen 0 {5,2,0x20}: disabled pulses leave ticks at 2
        vecs[13] = '{8'd1, 4'b0000, 0, 11'h0, 8'd0, 0};
        vecs[14] = '{8'd1, 4'b0000, 0, 11'h0, 8'd0, 0};
        vecs[15] = '{8'd1, 4'b0001, 0, 11'h0, 8'd0, 0};
        vecs[16] = '{8'd1, 4'b0001, 1, 11'h020, 8'd0, 2};
        vecs[17] = '{8'd1, 4'b0001, 0, 11'h0, 8'd0, 0};

        reset        = 1'b1;
        time_unit    = 1'b0;
        gens_used    = 8'd3;
        gens_en      = '0;
        gens_en[3]   = 1'b1;
        prog_gen_idx = 8'd3;
        prog_period  = 16'd4;
        prog_ticks   = 16'd2;
        prog_tag     = 11'h155;
        prog_v       = 1'b0;
        out_a        = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_out_v", {31'b0, out_v}, 0);
        check_output("reset_busy", {31'b0, busy}, 1);
        check_output("reset_missed", {31'b0, missed_unit}, 0);
        prog_v = 1'b1;
        #1;
        check_output("reset_prog_a", {31'b0, prog_a}, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_init();
        #1;
        check_output("idle_prog_a", {31'b0, prog_a}, 1);
        @(negedge clk);
        prog_v = 1'b0;

        for (int i = 0; i < 12; i++) apply_stimulus(i);

        // Two expiring generators, first one stalled for 5 cycles
        gens_used    = 8'd1;
        gens_en      = '0;
        gens_en[1:0] = 2'b11;
        program_gen(8'd0, 16'd1, 16'd1, 11'h010);
        program_gen(8'd1, 16'd1, 16'd1, 11'h011);
        out_a = 1'b0;
        pulse();
        wait_out_v("stall_first_v");
        for (int c = 0; c < 5; c++) begin
            check_output("stall_hold_v", {31'b0, out_v}, 1);
            check_output("stall_hold_tag", {21'b0, out_tag}, 32'h010);
            check_output("stall_hold_gidx", {24'b0, out_gen_idx}, 0);
            @(negedge clk);
        end
        out_a = 1'b1;
        @(negedge clk);
        out_a = 1'b0;
        check_output("ack_drop_v", {31'b0, out_v}, 0);
        @(negedge clk);
        check_output("second_v", {31'b0, out_v}, 1);
        check_output("second_tag", {21'b0, out_tag}, 32'h011);
        check_output("second_gidx", {24'b0, out_gen_idx}, 1);
        out_a = 1'b1;
        @(negedge clk);
        check_output("done_busy", {31'b0, busy}, 1);
        @(negedge clk);
        check_output("back_idle", {31'b0, busy}, 0);

        // Pulses during a stalled sweep: one queues, the next is lost
        out_a = 1'b0;
        pulse();
        wait_out_v("pend_first_v");
        prog_v = 1'b1;
        #1;
        check_output("sweep_prog_a", {31'b0, prog_a}, 0);
        @(negedge clk);
        prog_v = 1'b0;
        pulse();
        check_output("pend_missed0", {31'b0, missed_unit}, 0);
        pulse();
        check_output("pend_missed1", {31'b0, missed_unit}, 1);
        out_a = 1'b1;
        begin
            int cnt;
            cnt = 0;
            for (int c = 0; c < 30; c++) begin
                if (out_v) cnt++;
                @(negedge clk);
            end
            check_output("pend_total_emits", cnt, 4);
        end
        check_output("missed_sticky", {31'b0, missed_unit}, 1);
        check_output("pend_idle", {31'b0, busy}, 0);

        // Reset while an emit is stalled
        out_a = 1'b0;
        pulse();
        wait_out_v("rst_emit_v");
        reset = 1'b1;
        @(negedge clk);
        check_output("rst_out_v", {31'b0, out_v}, 0);
        check_output("rst_busy", {31'b0, busy}, 1);
        check_output("rst_missed", {31'b0, missed_unit}, 0);
        reset = 1'b0;
        wait_init();
        apply_stimulus(12);

        program_gen(8'd0, 16'd5, 16'd2, 11'h020);
        for (int i = 13; i < 18; i++) apply_stimulus(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
